// File: rtl/matraptor_perf_pkg.sv
// Shared types and constants for the MatRaptor performance monitor.
package matraptor_perf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_IDLE,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } perf_state_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/matraptor_perf_monitor_counter.sv
// Saturating event counter; clear loads 1 when an event lands on the same edge.
module perf_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  logic bump;
  assign bump = inc && !hold;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= bump ? WIDTH'(1) : '0;
    end else if (bump && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/matraptor_perf_monitor.sv
// Run-level performance monitor for the MatRaptor core: cycles, beats, completion.
// Optional stall counter enabled with macro MATRAPTOR_PERF_STALL_EN.
//
// state       | meaning
// S_IDLE      | waiting for the first accepted input beat
// S_RUN       | executing; cycle counter running
// S_WAIT_IDLE | last row merged; waiting for every PE to go idle
// S_DRAIN     | fixed DRAIN_CYC settling window
// S_DONE      | results valid, held until clear/reset
// S_TIMEOUT   | watchdog expired, results frozen
module matraptor_perf_monitor
  import matraptor_perf_pkg::*;
#(
  parameter int NUM_PES   = 4,
  parameter int IDX_W     = 16,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = 5,
  parameter int WDOG_CYC  = 5000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     in_ready,
  input  logic                     in_last,
  input  logic [IDX_W-1:0]         in_row,
  input  logic [NUM_PES-1:0]       pe_merge_done,
  input  logic [NUM_PES*IDX_W-1:0] pe_merge_row,
  input  logic [NUM_PES-1:0]       pe_idle,
  input  logic [NUM_PES-1:0]       out_valid,
  input  logic [NUM_PES-1:0]       out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         in_beats,
  output logic [NUM_PES*CNT_W-1:0] out_beats
`ifdef MATRAPTOR_PERF_STALL_EN
  ,
  output logic [CNT_W-1:0]         stall_count
`endif
);

  localparam int WD_W = $clog2(WDOG_CYC + 1);

  perf_state_t      state;
  logic [WD_W-1:0]  wdog;
  logic [7:0]       drain_cnt;
  logic [IDX_W-1:0] last_row;
  logic             last_seen;

  logic               clr_all, hs_in, any_hs, start, merge_hit, wdog_expire;
  logic [NUM_PES-1:0] hs_out;

  assign clr_all     = !rst_n || clear;
  assign hs_in       = in_valid && in_ready;
  assign hs_out      = out_valid & out_ready;
  assign any_hs      = hs_in || (|hs_out);
  assign start       = (state == S_IDLE) && hs_in;
  assign wdog_expire = !any_hs && (wdog == WD_W'(WDOG_CYC - 1));

  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < NUM_PES; i++) begin
      if (pe_merge_done[i] && (pe_merge_row[i*IDX_W +: IDX_W] == last_row)) merge_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_all) begin
      state     <= S_IDLE;
      wdog      <= '0;
      drain_cnt <= '0;
      last_row  <= '0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wdog <= '0;
          if (hs_in) begin
            state     <= S_RUN;
            last_seen <= in_last;
            if (in_last) last_row <= in_row;
          end
        end
        S_RUN: begin
          wdog <= any_hs ? '0 : wdog + WD_W'(1);
          if (hs_in && in_last) begin
            last_seen <= 1'b1;
            last_row  <= in_row;
          end
          // last_seen is registered, so a pulse alongside the in_last beat misses
          if (last_seen && merge_hit) state <= S_WAIT_IDLE;
          else if (wdog_expire)       state <= S_TIMEOUT;
        end
        S_WAIT_IDLE: begin
          wdog <= any_hs ? '0 : wdog + WD_W'(1);
          if (&pe_idle) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else if (wdog_expire) begin
            state <= S_TIMEOUT;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 8'(DRAIN_CYC - 1)) state <= S_DONE;
          else drain_cnt <= drain_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == S_RUN) || (state == S_WAIT_IDLE) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign timeout = (state == S_TIMEOUT);

  logic run_st, out_st;
  assign run_st = (state == S_RUN);
  assign out_st = busy;

  perf_sat_counter #(.WIDTH(CNT_W)) u_cycle (
    .clk(clk), .clear(clr_all || start), .inc(!clr_all), .hold(!run_st), .count(cycle_count)
  );

  perf_sat_counter #(.WIDTH(CNT_W)) u_in (
    .clk(clk), .clear(clr_all || start), .inc(hs_in && !clr_all),
    .hold(!(run_st || start)), .count(in_beats)
  );

  for (genvar g = 0; g < NUM_PES; g++) begin : g_out
    perf_sat_counter #(.WIDTH(CNT_W)) u_out (
      .clk(clk), .clear(clr_all || start), .inc(hs_out[g] && !clr_all),
      .hold(!out_st), .count(out_beats[g*CNT_W +: CNT_W])
    );
  end

`ifdef MATRAPTOR_PERF_STALL_EN
  perf_sat_counter #(.WIDTH(CNT_W)) u_stall (
    .clk(clk), .clear(clr_all || start), .inc(in_valid && !in_ready && !clr_all),
    .hold(!run_st), .count(stall_count)
  );
`endif

endmodule

// File: tb/tb_matraptor_perf_monitor.sv
// Directed bench for matraptor_perf_monitor (wide counters plus a 4-bit saturation copy).
module tb_matraptor_perf_monitor;
  import matraptor_perf_pkg::*;

  localparam int NP = 4;
  localparam int IW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, in_ready, in_last;
  logic [IW-1:0]    in_row;
  logic [NP-1:0]    pe_merge_done, pe_idle, out_valid, out_ready;
  logic [NP*IW-1:0] pe_merge_row;
  logic             busy, done, timeout, busy_s, done_s, timeout_s;
  logic [CW-1:0]    cycle_count, in_beats;
  logic [NP*CW-1:0] out_beats;
  logic [3:0]       cycle_count_s, in_beats_s;
  logic [NP*4-1:0]  out_beats_s;
`ifdef MATRAPTOR_PERF_STALL_EN
  logic [CW-1:0]    stall_count;
  logic [3:0]       stall_count_s;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matraptor_perf_monitor #(.NUM_PES(NP), .IDX_W(IW), .CNT_W(CW), .DRAIN_CYC(5), .WDOG_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_row(in_row), .pe_merge_done(pe_merge_done), .pe_merge_row(pe_merge_row),
    .pe_idle(pe_idle), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .in_beats(in_beats), .out_beats(out_beats)
`ifdef MATRAPTOR_PERF_STALL_EN
    , .stall_count(stall_count)
`endif
  );

  matraptor_perf_monitor #(.NUM_PES(NP), .IDX_W(IW), .CNT_W(4), .DRAIN_CYC(5), .WDOG_CYC(100)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_row(in_row), .pe_merge_done(pe_merge_done), .pe_merge_row(pe_merge_row),
    .pe_idle(pe_idle), .out_valid(out_valid), .out_ready(out_ready), .busy(busy_s), .done(done_s),
    .timeout(timeout_s), .cycle_count(cycle_count_s), .in_beats(in_beats_s), .out_beats(out_beats_s)
`ifdef MATRAPTOR_PERF_STALL_EN
    , .stall_count(stall_count_s)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clear = 0; in_valid = 0; in_ready = 0; in_last = 0; in_row = '0;
    pe_merge_done = '0; pe_merge_row = '0; pe_idle = 4'hF; out_valid = '0; out_ready = '0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  function automatic logic [CW-1:0] ob(input int pe);
    return out_beats[pe*CW +: CW];
  endfunction

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    check("rst_state", 64'(dut.state), 64'(S_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    check("rst_out", 64'(out_beats), 64'd0);
    rst_n = 1;

    // basic run: start at A, last row 7 at A+30, merge at A+50
    in_valid = 1; in_ready = 1; in_row = 16'd2;
    tick();
    in_valid = 0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_cycle", 64'(cycle_count), 64'd0);
    check("start_in", 64'(in_beats), 64'd1);
    repeat (29) tick();
    in_valid = 1; in_last = 1; in_row = 16'd7;
    tick();
    in_valid = 0; in_last = 0;
    check("basic_in", 64'(in_beats), 64'd2);
    repeat (19) tick();
    pe_merge_done = 4'b0001; pe_merge_row[0 +: IW] = 16'd7;
    tick();
    pe_merge_done = '0;
    check("basic_wait", 64'(dut.state), 64'(S_WAIT_IDLE));
    check("basic_cycle", 64'(cycle_count), 64'd50);
    tick();
    check("basic_drain", 64'(dut.state), 64'(S_DRAIN));
    check("basic_frozen", 64'(cycle_count), 64'd50);
    repeat (4) tick();
    check("drain_not_done", 64'(done), 64'd0);
    tick();
    check("basic_done", 64'(done), 64'd1);
    check("basic_notbusy", 64'(busy), 64'd0);
    do_clear();
    check("clr_done", 64'(done), 64'd0);
    check("clr_cycle", 64'(cycle_count), 64'd0);
    check("clr_in", 64'(in_beats), 64'd0);

    // early merge (before and with in_last), multi-PE out beats
    in_valid = 1; in_ready = 1; in_row = 16'd1;
    tick();
    in_valid = 0;
    pe_merge_done = 4'b0100; pe_merge_row[2*IW +: IW] = 16'd7;
    tick();
    check("early_pre", 64'(dut.state), 64'(S_RUN));
    in_valid = 1; in_last = 1; in_row = 16'd7;
    tick();
    in_valid = 0; in_last = 0; pe_merge_done = '0;
    check("early_same", 64'(dut.state), 64'(S_RUN));
    out_valid = 4'b1111; out_ready = 4'b1001; tick();
    out_valid = 4'b0011; out_ready = 4'b1111; tick();
    out_valid = 4'b0001; out_ready = 4'b0001; tick();
    out_valid = '0; out_ready = '0;
    pe_idle = 4'b1101; pe_merge_done = 4'b0100;
    tick();
    pe_merge_done = '0;
    check("mpe_wait", 64'(dut.state), 64'(S_WAIT_IDLE));
    in_valid = 1; out_valid = 4'b0010; out_ready = 4'b0010;
    tick();
    in_valid = 0; out_valid = '0; out_ready = '0;
    tick();
    check("mpe_hold", 64'(dut.state), 64'(S_WAIT_IDLE));
    check("mpe_in", 64'(in_beats), 64'd2);
    pe_idle = 4'hF;
    tick();
    check("mpe_drain", 64'(dut.state), 64'(S_DRAIN));
    repeat (5) tick();
    check("mpe_done", 64'(done), 64'd1);
    in_valid = 1; out_valid = 4'hF; out_ready = 4'hF;
    tick();
    in_valid = 0; out_valid = '0; out_ready = '0;
    check("mpe_out0", 64'(ob(0)), 64'd3);
    check("mpe_out1", 64'(ob(1)), 64'd2);
    check("mpe_out2", 64'(ob(2)), 64'd0);
    check("mpe_out3", 64'(ob(3)), 64'd1);
    check("done_ign_in", 64'(in_beats), 64'd2);
    do_clear();

    // watchdog: 100 edges without handshake after start
    in_valid = 1; in_ready = 1; in_row = 16'd4;
    tick();
    in_valid = 0;
    repeat (99) tick();
    check("wdog_pre", 64'(dut.state), 64'(S_RUN));
    tick();
    check("wdog_to", 64'(timeout), 64'd1);
    check("wdog_busy", 64'(busy), 64'd0);
    check("wdog_cycle", 64'(cycle_count), 64'd100);
    in_valid = 1; out_valid = 4'h1; out_ready = 4'h1;
    tick(); tick();
    in_valid = 0; out_valid = '0; out_ready = '0;
    check("wdog_sticky", 64'(timeout), 64'd1);
    check("wdog_frz_c", 64'(cycle_count), 64'd100);
    check("wdog_frz_in", 64'(in_beats), 64'd1);
    do_clear();
    check("wdog_clr_st", 64'(dut.state), 64'(S_IDLE));
    check("wdog_clr_to", 64'(timeout), 64'd0);
    check("wdog_clr_c", 64'(cycle_count), 64'd0);
    check("wdog_clr_in", 64'(in_beats), 64'd0);

    // saturation on the 4-bit copy
    in_valid = 1; in_ready = 1; in_row = 16'd9;
    repeat (20) tick();
    in_valid = 0;
    check("sat_in_s", 64'(in_beats_s), 64'd15);
    check("sat_cyc_s", 64'(cycle_count_s), 64'd15);
    check("sat_in_w", 64'(in_beats), 64'd20);
    do_clear();

    // reset in DRAIN, with three stall cycles in RUN
    in_valid = 1; in_ready = 1; in_last = 1; in_row = 16'd3;
    tick();
    in_last = 0; in_ready = 0;
    repeat (3) tick();
    in_valid = 0;
`ifdef MATRAPTOR_PERF_STALL_EN
    check("stall_cnt", 64'(stall_count), 64'd3);
`endif
    pe_merge_done = 4'b0001; pe_merge_row[0 +: IW] = 16'd3;
    tick();
    pe_merge_done = '0;
    tick(); tick();
    check("rdr_drain", 64'(dut.state), 64'(S_DRAIN));
    rst_n = 0;
    tick();
    check("rdr_state", 64'(dut.state), 64'(S_IDLE));
    check("rdr_busy", 64'(busy), 64'd0);
    check("rdr_cycle", 64'(cycle_count), 64'd0);
    check("rdr_in", 64'(in_beats), 64'd0);
`ifdef MATRAPTOR_PERF_STALL_EN
    check("rdr_stall", 64'(stall_count), 64'd0);
`endif
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matraptor_perf_monitor.md
MATRAPTOR_PERF_MONITOR -- requirements
Module: matraptor_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_PES, default 4: number of PE output channels monitored.
REQ-002 SHALL have parameter IDX_W, default 16: row index width.
REQ-003 SHALL have parameter CNT_W, default 32: width of every counter output.
REQ-004 SHALL have parameter DRAIN_CYC, default 5: cycles spent in DRAIN before DONE, range 1..255.
REQ-005 SHALL have parameter WDOG_CYC, default 5000000: inactivity limit in cycles (10 ms at 500 MHz).
REQ-006 SHALL have ports in this order:
  clk  in  1  clock.
  rst_n  in  1  reset, synchronous, active-low.
  clear  in  1  synchronous restart to IDLE.
  in_valid / in_ready / in_last  in  1 each  core input handshake.
  in_row  in  IDX_W  row of the accepted input beat.
  pe_merge_done  in  NUM_PES  one-cycle pulse per PE at row-merge completion.
  pe_merge_row  in  NUM_PES x IDX_W  row merged by each PE, valid with its pulse.
  pe_idle  in  NUM_PES  PE has no pending work.
  out_valid / out_ready  in  NUM_PES each  per-PE output handshake.
  busy  out  1  state is RUN, WAIT_IDLE or DRAIN.
  done  out  1  state is DONE.
  timeout  out  1  state is TIMEOUT.
  cycle_count  out  CNT_W  execution cycles, start to stop.
  in_beats  out  CNT_W  accepted input beats.
  out_beats  out  NUM_PES x CNT_W  accepted output beats per PE.

Function
REQ-007 SHALL implement states IDLE, RUN, WAIT_IDLE, DRAIN, DONE, TIMEOUT.
REQ-008 SHALL move IDLE->RUN on the first in_valid&&in_ready edge; cycle_count cleared to 0 and in_beats set to 1 on that edge.
REQ-009 SHALL increment cycle_count by 1 on every edge while in RUN, including the stop edge; handshake at edge 10, stop pulse at edge 20 -> cycle_count=10.
REQ-010 SHALL count in_beats on every accepted input beat in RUN.
REQ-011 SHALL register last_row=in_row and set last_seen when an accepted beat has in_last=1.
REQ-012 SHALL move RUN->WAIT_IDLE on an edge where last_seen=1 and any PE pulses pe_merge_done with pe_merge_row==last_row; cycle_count freezes afterwards.
REQ-013 SHALL ignore merge pulses before last_seen, including a pulse in the same cycle as the in_last handshake.
REQ-014 SHALL move WAIT_IDLE->DRAIN on the first edge with &pe_idle=1.
REQ-015 SHALL stay in DRAIN exactly DRAIN_CYC cycles, then move to DONE; DONE holds until clear or reset.
REQ-016 SHALL count out_beats[i] on out_valid[i]&&out_ready[i] in RUN, WAIT_IDLE and DRAIN only.
REQ-017 SHALL run a watchdog in RUN and WAIT_IDLE, cleared by any input or output handshake; reaching WDOG_CYC moves to TIMEOUT (sticky), counters frozen.
REQ-018 SHALL saturate every counter at all-ones, with no wrap-around.
REQ-019 SHALL ignore handshakes in DONE and TIMEOUT.
REQ-020 SHALL give clear priority over all transitions: next state IDLE, all counters and flags zeroed.

Reset
REQ-021 SHALL, while rst_n=0 at a clk edge, enter IDLE with busy=done=timeout=0, all counters 0, last_seen=0; reset mid-run discards results.

Configuration
REQ-022 SHALL, with MATRAPTOR_PERF_STALL_EN defined, add output stall_count (CNT_W) after out_beats, counting in_valid&&!in_ready cycles in RUN, saturating, cleared like other counters.
REQ-023 SHALL, without MATRAPTOR_PERF_STALL_EN, omit the stall_count port and logic entirely.

Structure
REQ-024 SHALL place the state enum perf_state_t and the default CNT_W constant in package matraptor_perf_pkg.
REQ-025 SHALL implement each counter as one sub-module, perf_sat_counter: clear, inc and hold inputs; saturating; WIDTH parameter.

Verification
REQ-026 Bench SHALL cover basic run: first handshake edge 10, in_last row 7 at edge 40, PE0 merge row 7 at edge 60, all idle -> cycle_count=50, done 5 cycles after DRAIN entry.
REQ-027 Bench SHALL cover early merge: merge row 7 before in_last, or in the same cycle as it -> ignored, state stays RUN.
REQ-028 Bench SHALL cover multi-PE: PE2 merges last row while PE1 is not idle -> WAIT_IDLE held until pe_idle=4'hF; out_beats per PE match beats sent.
REQ-029 Bench SHALL cover watchdog: WDOG_CYC=100, no handshakes for 100 cycles in RUN -> timeout=1; clear -> IDLE, all counters 0.
REQ-030 Bench SHALL cover saturation: CNT_W=4, 20 input beats -> in_beats=15.
REQ-031 Bench SHALL cover reset mid-DRAIN -> IDLE with all outputs 0 on the next edge; with the macro defined, 3 stall cycles -> stall_count=3.
